// File: rtl/fp_pkg.sv
// Shared types and constants for the fp32 add scheduler.
package fp_pkg;

  localparam int unsigned FP_W     = 32;
  // Widest requester index supported (N up to 16).
  localparam int unsigned ID_MAX_W = 4;

  // Operand stage payload.
  typedef struct packed {
    logic [FP_W-1:0]     a;
    logic [FP_W-1:0]     b;
    logic [ID_MAX_W-1:0] id;
  } s1_payload_t;

  // Response stage payload.
  typedef struct packed {
    logic [FP_W-1:0]     sum;
    logic [ID_MAX_W-1:0] id;
  } rsp_t;

endpackage

// File: rtl/fp32_add_core.sv
// Combinational single-precision adder, truncating toward zero.
// Zero/denormal exponents read as zero; an exact zero result is +0; overflow gives Inf.
module fp32_add_core
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  logic            a_big;
  logic [FP_W-1:0] big;
  logic [FP_W-1:0] sml;
  logic [7:0]      eb;
  logic [7:0]      es;
  logic [7:0]      ediff;
  logic [26:0]     mb;
  logic [26:0]     ms;
  logic [26:0]     ms_sh;
  logic [26:0]     mask;
  logic            eff_sub;
  logic [27:0]     mag;
  logic [4:0]      lz;
  logic [26:0]     norm;
  logic [9:0]      exp_r;
  logic [22:0]     frac;

  // Align the smaller operand, add/subtract magnitudes, renormalise and pack.
  always_comb begin
    mask  = '0;
    a_big = (a[30:0] >= b[30:0]);
    big   = a_big ? a : b;
    sml   = a_big ? b : a;
    eb    = big[30:23];
    es    = sml[30:23];
    // Mantissas carry 3 extra low bits (guard, round, sticky).
    mb    = (eb == 8'd0) ? '0 : {1'b1, big[22:0], 3'b000};
    ms    = (es == 8'd0) ? '0 : {1'b1, sml[22:0], 3'b000};
    ediff = eb - es;
    if (ediff >= 8'd27) begin
      ms_sh = {26'd0, |ms};
    end else begin
      mask  = (27'd1 << ediff[4:0]) - 27'd1;
      ms_sh = (ms >> ediff[4:0]) | {26'd0, |(ms & mask)};
    end
    eff_sub = big[31] ^ sml[31];
    mag     = eff_sub ? ({1'b0, mb} - {1'b0, ms_sh}) : ({1'b0, mb} + {1'b0, ms_sh});
    // Leading-zero count below the carry bit; the highest set bit wins.
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (mag[i]) lz = 5'(26 - i);
    end
    norm = mag[26:0] << lz;
    if (mag[27]) begin
      exp_r = {2'b00, eb} + 10'd1;
      frac  = 23'(mag >> 4);
    end else begin
      exp_r = {2'b00, eb} - {5'd0, lz};
      frac  = 23'(norm >> 3);
    end
    if (mag == '0 || exp_r[9] || exp_r == '0) begin
      sum = '0;
    end else if (exp_r >= 10'd255) begin
      sum = {big[31], 8'hFF, 23'd0};
    end else begin
      sum = {big[31], exp_r[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one fp32 adder among N requesters.
// Two register stages (operands, result) with full-throughput backpressure.
module fp_add_scheduler
  import fp_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*FP_W-1:0] req_a,
  input  logic [N*FP_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [FP_W-1:0]   rsp_sum,
  output logic              busy
);

  logic            s1_v;
  logic            s2_v;
  s1_payload_t     s1;
  rsp_t            s2;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_nxt;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  idx;
  logic [IDW:0]    idx_w;
  logic            gnt_found;
  logic            hs;
  logic            s1_adv;
  logic            s2_adv;
  logic [FP_W-1:0] sel_a;
  logic [FP_W-1:0] sel_b;
  logic [FP_W-1:0] add_sum;

  // Stage advance conditions and round-robin grant search from rr_ptr.
  always_comb begin
    s2_adv    = !s2_v || rsp_ready;
    s1_adv    = !s1_v || s2_adv;
    gnt_found = 1'b0;
    gnt       = '0;
    idx_w     = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_w = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx_w >= (IDW+1)'(N)) idx_w = idx_w - (IDW+1)'(N);
      idx = idx_w[IDW-1:0];
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
    // Gating with rst_n keeps req_ready low throughout reset.
    hs        = gnt_found && s1_adv && rst_n;
    req_ready = '0;
    if (hs) req_ready[gnt] = 1'b1;
    rr_nxt = (gnt == IDW'(N - 1)) ? '0 : gnt + 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IDW'(i) == gnt) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  fp32_add_core u_add (
    .a   (s1.a),
    .b   (s1.b),
    .sum (add_sum)
  );

  // Pipeline registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s1     <= '0;
      s2     <= '0;
      rr_ptr <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= hs;
        if (hs) begin
          s1.a  <= sel_a;
          s1.b  <= sel_b;
          s1.id <= ID_MAX_W'(gnt);
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        // Only capture real results so the output holds the last sum when idle.
        if (s1_v) begin
          s2.sum <= add_sum;
          s2.id  <= s1.id;
        end
      end
      if (hs) rr_ptr <= rr_nxt;
    end
  end

  // Response channel and status.
  always_comb begin
    rsp_valid = s2_v;
    rsp_sum   = s2.sum;
    rsp_id    = IDW'(s2.id);
    busy      = s1_v | s2_v;
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler: a round-robin/in-order queue model predicts
// grants and responses; operands are small integers so sums are exact in fp32.
module tb_fp_add_scheduler;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_sum;
  logic              busy;

  fp_add_scheduler #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] sum;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_sum_arr [N];
  int          rr = 0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Exact integer -> fp32 encoding (|v| < 2^23).
  function automatic logic [31:0] i2f(input int v);
    logic [31:0] m;
    int          p;
    logic        s;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    m = m << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int rnd_int();
    if ($urandom_range(0, 7) == 0) return 0;
    return int'($urandom_range(0, 2097152)) - 1048576;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    exp_sum_arr[i]    = e;
  endtask

  task automatic rand_ops(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      int x;
      int y;
      x = rnd_int();
      y = ($urandom_range(0, 7) == 0) ? -x : rnd_int();
      set_op(i, i2f(x), i2f(y), i2f(x + y));
    end
    req_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant model: round-robin from rr; accept when fewer than 2 in flight or consumer ready.
  always @(negedge clk) begin
    if (rst_n) begin
      int          g;
      int          idx;
      bit          can;
      logic [N-1:0] exp_rdy;
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      can     = (sb.size() < 2) || rsp_ready;
      exp_rdy = '0;
      if (g >= 0 && can) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (g >= 0 && can) begin
        sb.push_back('{id: g, sum: exp_sum_arr[g], cyc: cyc});
        rr = (g + 1) % N;
      end
    end
  end

  // Response monitor: in-order, minimum latency 2, held while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      int inflight;
      bit exp_v;
      inflight = 0;
      foreach (sb[i]) if (sb[i].cyc < cyc) inflight++;
      check("busy", busy, (inflight > 0));
      exp_v = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v && rsp_valid) begin
        check("rsp_id", rsp_id, sb[0].id);
        check("rsp_sum", rsp_sum, sb[0].sum);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int hs_cnt;
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) exp_sum_arr[i] = '0;
    #2;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_sum", rsp_sum, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 0);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single request, 1.5 + 3.0, latency 2.
    set_op(0, 32'h3FC00000, 32'h40400000, 32'h40900000);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_not_yet", rsp_valid, 0);
    step();
    @(negedge clk);
    check("t1_lat_valid", rsp_valid, 1);
    check("t1_id", rsp_id, 0);
    check("t1_sum", rsp_sum, 32'h40900000);
    step();

    // Mixed sign and zero operand on requester 2.
    set_op(2, 32'h41000000, 32'hC0E00000, 32'h3F800000);
    req_valid = 4'b0100;
    step();
    set_op(2, 32'h00000000, 32'h40400000, 32'h40400000);
    step();
    req_valid = '0;
    repeat (4) step();

    // Fairness: all valid for 12 cycles.
    repeat (12) begin
      rand_ops('1);
      step();
    end
    req_valid = '0;
    repeat (4) step();

    // Backpressure: exactly two handshakes, then release.
    hs_cnt    = 0;
    rand_ops('1);
    rsp_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (|req_ready) hs_cnt++;
      step();
    end
    check("bp_handshakes", hs_cnt, 2);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", {31'd0, |req_ready}, 1);
    step();
    repeat (3) step();
    req_valid = '0;
    repeat (4) step();

    // Random traffic with random backpressure.
    repeat (300) begin
      rand_ops(4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();

    // Reset mid-operation with both stages full.
    rand_ops('1);
    rsp_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    sb.delete();
    rr = 0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rsp_sum", rsp_sum, 0);
    check("midrst_rsp_id", rsp_id, 0);
    step();
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_reset_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    repeat (5) step();
    check("drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
